tdc_stim_gen: RTL



---
 rtl/tdc_pkg.sv | 28 ++
 rtl/tdc_interval_counter.sv | 35 +++
 rtl/tdc_stim_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg
//   Definitions shared by the TDC stimulus generator and the fine-counter
//   test harness: state encoding, default field widths and a width helper.
package tdc_pkg;

   localparam int DEF_DELAY_W = 16;
   localparam int DEF_WIDTH_W = 8;
   localparam int DEF_COUNT_W = 16;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ARM  = 3'd1;
   localparam logic [2:0] ST_FIRE = 3'd2;
   localparam logic [2:0] ST_HOLD = 3'd3;
   localparam logic [2:0] ST_GAP  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_ARM  = ST_ARM,
      S_FIRE = ST_FIRE,
      S_HOLD = ST_HOLD,
      S_GAP  = ST_GAP
   } tdc_state_e;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tdc_interval_counter.sv
// tdc_interval_counter
//   Loadable down-counter that parks at zero, used to time the delay,
//   hold and gap phases of the stimulus generator.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   i_load       load i_load_val (takes priority over i_dec)
//   i_load_val   value loaded; the phase lasts i_load_val+1 cycles
//   i_dec        decrement by one, no effect once at zero
//   o_zero       count is zero (last cycle of the current phase)
module tdc_interval_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/tdc_stim_gen.sv
// tdc_stim_gen
//   Emits N start/stop pairs for the fine TDC channel. Each pair holds
//   start for D cycles, then start+stop for one cycle, then start alone for
//   W-1 cycles; pairs are separated by G idle cycles.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_valid/cfg_ready configuration handshake (ready only in IDLE)
//   cfg_delay/width/gap D, W, G in cycles (D,W >= 1, G >= 2 after saturation)
//   cfg_count           N pairs, 0 completes immediately
//   abort               cancel any running sequence
//   start_o, stop_o     registered pulse outputs
//   busy, done          activity flag, one-cycle completion pulse
//   pair_cnt            pairs completed since the last accept
module tdc_stim_gen
   import tdc_pkg::*;
#(
   parameter int DELAY_W = DEF_DELAY_W,
   parameter int WIDTH_W = DEF_WIDTH_W,
   parameter int COUNT_W = DEF_COUNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic [WIDTH_W-1:0] cfg_width,
   input  logic [DELAY_W-1:0] cfg_gap,
   input  logic [COUNT_W-1:0] cfg_count,
   input  logic               abort,
   output logic               start_o,
   output logic               stop_o,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] pair_cnt
);

   localparam int CNT_W = max_w(DELAY_W, WIDTH_W);

   // Config values are stored as (phase length - 1) so they load straight
   // into the interval counter.
   function automatic logic [DELAY_W-1:0] sat_delay_m1(input logic [DELAY_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   function automatic logic [WIDTH_W-1:0] sat_width_m1(input logic [WIDTH_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   function automatic logic [DELAY_W-1:0] sat_gap_m1(input logic [DELAY_W-1:0] v);
      return (v < DELAY_W'(2)) ? DELAY_W'(1) : v - 1'b1;
   endfunction

   tdc_state_e          r_state;
   tdc_state_e          w_next;
   logic [DELAY_W-1:0]  r_delay_m1;
   logic [WIDTH_W-1:0]  r_width_m1;
   logic [DELAY_W-1:0]  r_gap_m1;
   logic [COUNT_W-1:0]  r_remain;
   logic [COUNT_W-1:0]  r_pair_cnt;
   logic                r_start;
   logic                r_stop;
   logic                r_done;

   logic                w_accept;
   logic                w_last;
   logic                w_pair_end;
   logic                w_ld;
   logic                w_dec;
   logic [CNT_W-1:0]    w_ld_val;
   logic                w_zero;
   logic                w_start_nx;
   logic                w_stop_nx;
   logic                w_done_nx;

   assign cfg_ready = (r_state == S_IDLE) && !reset;
   assign w_accept  = cfg_valid && cfg_ready;
   assign w_last    = (r_remain <= COUNT_W'(1));

   tdc_interval_counter #(.CNT_W(CNT_W)) u_interval (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_ld),
      .i_load_val (w_ld_val),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_next     = r_state;
      w_ld       = 1'b0;
      w_ld_val   = '0;
      w_dec      = 1'b0;
      w_pair_end = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (w_accept && (cfg_count != '0)) begin
               w_next   = S_ARM;
               w_ld     = 1'b1;
               w_ld_val = CNT_W'(sat_delay_m1(cfg_delay));
            end
         end
         S_ARM: begin
            if (w_zero) w_next = S_FIRE;
            else        w_dec  = 1'b1;
         end
         S_FIRE: begin
            // W=1 ends the pair right after the stop cycle, no HOLD phase
            if (r_width_m1 == '0) begin
               w_pair_end = 1'b1;
            end else begin
               w_next   = S_HOLD;
               w_ld     = 1'b1;
               w_ld_val = CNT_W'(r_width_m1 - 1'b1);
            end
         end
         S_HOLD: begin
            if (w_zero) w_pair_end = 1'b1;
            else        w_dec      = 1'b1;
         end
         S_GAP: begin
            if (w_zero) begin
               w_next   = S_ARM;
               w_ld     = 1'b1;
               w_ld_val = CNT_W'(r_delay_m1);
            end else begin
               w_dec = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase

      if (w_pair_end) begin
         if (w_last) begin
            w_next = S_IDLE;
         end else begin
            w_next   = S_GAP;
            w_ld     = 1'b1;
            w_ld_val = CNT_W'(r_gap_m1);
         end
      end

      // abort overrides everything: no pair completion, no done
      if (abort && (r_state != S_IDLE)) begin
         w_next     = S_IDLE;
         w_ld       = 1'b0;
         w_dec      = 1'b0;
         w_pair_end = 1'b0;
      end
   end

   // Outputs are registered from the next state so start/stop come from flops.
   assign w_start_nx = (w_next == S_ARM) || (w_next == S_FIRE) || (w_next == S_HOLD);
   assign w_stop_nx  = (w_next == S_FIRE);
   assign w_done_nx  = (w_pair_end && w_last) || (w_accept && (cfg_count == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
         r_done     <= 1'b0;
         r_pair_cnt <= '0;
         r_remain   <= '0;
      end else begin
         r_state <= w_next;
         r_start <= w_start_nx;
         r_stop  <= w_stop_nx;
         r_done  <= w_done_nx;
         if (w_accept) begin
            r_pair_cnt <= '0;
            r_remain   <= cfg_count;
         end else if (w_pair_end) begin
            if (r_pair_cnt != '1) r_pair_cnt <= r_pair_cnt + 1'b1;
            if (r_remain != '0)   r_remain   <= r_remain - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_delay_m1 <= sat_delay_m1(cfg_delay);
         r_width_m1 <= sat_width_m1(cfg_width);
         r_gap_m1   <= sat_gap_m1(cfg_gap);
      end
   end

   assign start_o  = r_start;
   assign stop_o   = r_stop;
   assign done     = r_done;
   assign busy     = (r_state != S_IDLE);
   assign pair_cnt = r_pair_cnt;

endmodule
